// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential fixed-point divider.
//   div_state_t : FSM encoding used by param_seq_divider
//   DEF_*       : default parameter values for the divider top
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    localparam int unsigned DEF_DIVIDEND_W = 18;
    localparam int unsigned DEF_DIVISOR_W  = 18;
    localparam int unsigned DEF_FRAC_W     = 8;
    localparam int unsigned DEF_OUT_W      = 8;

endpackage

// File: rtl/div_nr_step.sv
// One combinational radix-2 non-restoring division iteration.
//   i_a      : partial remainder, AW-bit two's complement
//   i_q      : quotient/dividend shift register, N bits
//   i_m      : divisor, zero-extended to AW bits
//   o_a_next : partial remainder after shift and add/subtract
//   o_q_next : shift register after shift with the new quotient bit in bit 0
// Requires N >= 2.
module div_nr_step
    import div_pkg::*;
#(
    parameter int unsigned AW = DEF_DIVISOR_W + 1,
    parameter int unsigned N  = DEF_DIVIDEND_W + DEF_FRAC_W
) (
    input  logic [AW-1:0] i_a,
    input  logic [N-1:0]  i_q,
    input  logic [AW-1:0] i_m,
    output logic [AW-1:0] o_a_next,
    output logic [N-1:0]  o_q_next
);

    logic [AW-1:0] w_a_shl;

    // {A,Q} <<= 1: the top dividend bit moves into the accumulator.
    assign w_a_shl  = {i_a[AW-2:0], i_q[N-1]};
    // Sign of the pre-shift accumulator selects restore-by-add or subtract.
    assign o_a_next = i_a[AW-1] ? (w_a_shl + i_m) : (w_a_shl - i_m);
    assign o_q_next = {i_q[N-2:0], ~o_a_next[AW-1]};

endmodule

// File: rtl/param_seq_divider.sv
// Sequential non-restoring divider computing (dividend << FRAC_W) / divisor,
// one quotient bit per clock, with start/busy/done handshake.
//   clk, nrst   : clock (rising edge), asynchronous active-low reset
//   start       : load operands and begin (aborts an operation in RUN)
//   dividend    : numerator, unsigned
//   divisor     : denominator, unsigned
//   busy        : high while state is RUN or FINISH
//   done        : one-cycle pulse, result outputs updated this cycle
//   quotient    : full quotient, DIVIDEND_W+FRAC_W bits
//   remainder   : corrected remainder
//   q_sat       : quotient clamped to 2**OUT_W-1
//   div_by_zero : set with done when the divisor was zero
module param_seq_divider
    import div_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W,
    parameter int unsigned FRAC_W     = DEF_FRAC_W,
    parameter int unsigned OUT_W      = DEF_OUT_W
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start,
    input  logic [DIVIDEND_W-1:0]        dividend,
    input  logic [DIVISOR_W-1:0]         divisor,
    output logic                         busy,
    output logic                         done,
    output logic [DIVIDEND_W+FRAC_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]         remainder,
    output logic [OUT_W-1:0]             q_sat,
    output logic                         div_by_zero
);

    localparam int unsigned N  = DIVIDEND_W + FRAC_W;
    localparam int unsigned AW = DIVISOR_W + 1;
    localparam int unsigned CW = $clog2(N + 1);

    div_state_t           r_state, w_state_nxt;
    logic [AW-1:0]        r_a, w_a_nxt;
    logic [N-1:0]         r_q, w_q_nxt;
    logic [DIVISOR_W-1:0] r_m, w_m_nxt;
    logic [CW-1:0]        r_count, w_count_nxt;
    logic                 r_dbz_pend, w_dbz_nxt;
    logic                 w_commit;

    logic [AW-1:0]        w_step_a;
    logic [N-1:0]         w_step_q;
    logic [AW-1:0]        w_a_fix;
    logic [N-1:0]         w_q_hi;
    logic                 w_q_over;

    logic                 r_done;
    logic [N-1:0]         r_quotient;
    logic [DIVISOR_W-1:0] r_remainder;
    logic [OUT_W-1:0]     r_q_sat;
    logic                 r_div_by_zero;

    div_nr_step #(
        .AW (AW),
        .N  (N)
    ) u_step (
        .i_a      (r_a),
        .i_q      (r_q),
        .i_m      ({1'b0, r_m}),
        .o_a_next (w_step_a),
        .o_q_next (w_step_q)
    );

    // Final remainder correction and saturation detect for the commit cycle.
    assign w_a_fix  = r_a[AW-1] ? (r_a + {1'b0, r_m}) : r_a;
    assign w_q_hi   = r_q >> OUT_W;
    assign w_q_over = |w_q_hi;

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_q_nxt     = r_q;
        w_m_nxt     = r_m;
        w_count_nxt = r_count;
        w_dbz_nxt   = r_dbz_pend;
        w_commit    = 1'b0;
        unique case (r_state)
            IDLE: ;
            RUN: begin
                w_a_nxt     = w_step_a;
                w_q_nxt     = w_step_q;
                w_count_nxt = r_count + CW'(1);
                if (r_count == CW'(N - 1)) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // A new start wins in every state; in FINISH the old result still commits.
        if (start) begin
            w_a_nxt     = '0;
            w_q_nxt     = {dividend, {FRAC_W{1'b0}}};
            w_m_nxt     = divisor;
            w_count_nxt = '0;
            w_dbz_nxt   = (divisor == '0);
            w_state_nxt = (divisor == '0) ? FINISH : RUN;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_q        <= '0;
            r_m        <= '0;
            r_count    <= '0;
            r_dbz_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_q        <= w_q_nxt;
            r_m        <= w_m_nxt;
            r_count    <= w_count_nxt;
            r_dbz_pend <= w_dbz_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_q_sat       <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                if (r_dbz_pend) begin
                    // Q was never shifted, so its top field is still the dividend.
                    r_quotient    <= '1;
                    r_q_sat       <= '1;
                    r_remainder   <= DIVISOR_W'(r_q[N-1:FRAC_W]);
                    r_div_by_zero <= 1'b1;
                end else begin
                    r_quotient    <= r_q;
                    r_q_sat       <= w_q_over ? '1 : OUT_W'(r_q);
                    r_remainder   <= DIVISOR_W'(w_a_fix);
                    r_div_by_zero <= 1'b0;
                end
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign q_sat       = r_q_sat;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_param_seq_divider.sv
// Directed bench: default instance (N=26, OUT_W=8) and a FRAC_W=0, OUT_W=18 instance
// sharing operand buses and reset, each with its own start.
module tb_param_seq_divider;

    logic        clk;
    logic        nrst;
    logic        start1, start2;
    logic [17:0] dividend;
    logic [17:0] divisor;

    logic        busy1, done1, dbz1;
    logic [25:0] q1;
    logic [17:0] rem1;
    logic [7:0]  qs1;

    logic        busy2, done2, dbz2;
    logic [17:0] q2;
    logic [17:0] rem2;
    logic [17:0] qs2;

    int n_total = 0;
    int n_bad   = 0;

    param_seq_divider u_dut1 (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start1),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy1),
        .done        (done1),
        .quotient    (q1),
        .remainder   (rem1),
        .q_sat       (qs1),
        .div_by_zero (dbz1)
    );

    param_seq_divider #(
        .DIVIDEND_W (18),
        .DIVISOR_W  (18),
        .FRAC_W     (0),
        .OUT_W      (18)
    ) u_dut2 (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start2),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy2),
        .done        (done2),
        .quotient    (q2),
        .remainder   (rem2),
        .q_sat       (qs2),
        .div_by_zero (dbz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // Drive start for exactly one rising edge; returns at the negedge after that edge.
    task automatic start_op(input int inst, input logic [17:0] dvd, input logic [17:0] dvs);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        if (inst == 1) start1 = 1'b1;
        else           start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Entered at cycle 1 after the sampling edge; lat = cycle index where done is seen.
    task automatic wait_done(input int inst, input string tag, output int lat);
        logic d;
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
            d = (inst == 1) ? done1 : done2;
        end while (!d && lat < 200);
        check_eq({tag, "_done_seen"}, 64'(d), 64'd1);
    endtask

    task automatic run_op(input int inst, input string tag,
                          input logic [17:0] dvd, input logic [17:0] dvs,
                          input int exp_lat, input logic [63:0] exp_q,
                          input logic [63:0] exp_rem, input logic [63:0] exp_qs,
                          input logic exp_dbz);
        int lat;
        start_op(inst, dvd, dvs);
        check_eq({tag, "_busy"}, 64'((inst == 1) ? busy1 : busy2), 64'd1);
        wait_done(inst, tag, lat);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (inst == 1) begin
            check_eq({tag, "_q"},   64'(q1),   exp_q);
            check_eq({tag, "_rem"}, 64'(rem1), exp_rem);
            check_eq({tag, "_qs"},  64'(qs1),  exp_qs);
            check_eq({tag, "_dbz"}, 64'(dbz1), 64'(exp_dbz));
        end else begin
            check_eq({tag, "_q"},   64'(q2),   exp_q);
            check_eq({tag, "_rem"}, 64'(rem2), exp_rem);
            check_eq({tag, "_qs"},  64'(qs2),  exp_qs);
            check_eq({tag, "_dbz"}, 64'(dbz2), 64'(exp_dbz));
        end
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 64'((inst == 1) ? done1 : done2), 64'd0);
    endtask

    initial begin
        int          lat;
        int          n_done;
        logic [17:0] rdvd, rdvs;

        nrst     = 1'b0;
        start1   = 1'b0;
        start2   = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy1), 64'd0);
        check_eq("rst_done", 64'(done1), 64'd0);
        check_eq("rst_q",    64'(q1),    64'd0);
        check_eq("rst_rem",  64'(rem1),  64'd0);
        check_eq("rst_qs",   64'(qs1),   64'd0);
        check_eq("rst_dbz",  64'(dbz1),  64'd0);
        nrst = 1'b1;

        // (3<<8)/4 = 192 r0; (1000<<8)/7 = 256000/7 = 36571 r3; 5/0 -> all-ones, r5
        run_op(1, "d3_4",    18'd3,    18'd4, 28, 64'd192,      64'd0, 64'hC0, 1'b0);
        run_op(1, "d1000_7", 18'd1000, 18'd7, 28, 64'd36571,    64'd3, 64'hFF, 1'b0);
        run_op(1, "d5_0",    18'd5,    18'd0, 2,  64'h3FFFFFF,  64'd5, 64'hFF, 1'b1);

        // Abort: 3/4 restarted at cycle 10 by 8/2 -> (8<<8)/2 = 1024
        start_op(1, 18'd3, 18'd4);
        n_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done1) n_done++;
        end
        check_eq("abort_hold_q", 64'(q1), 64'h3FFFFFF);
        start_op(1, 18'd8, 18'd2);
        if (done1) n_done++;
        check_eq("abort_no_done", 64'(n_done), 64'd0);
        wait_done(1, "abort", lat);
        check_eq("abort_lat", 64'(lat), 64'd28);
        check_eq("abort_q",   64'(q1),   64'd1024);
        check_eq("abort_rem", 64'(rem1), 64'd0);
        check_eq("abort_qs",  64'(qs1),  64'hFF);
        check_eq("abort_dbz", 64'(dbz1), 64'd0);

        // Asynchronous reset in the middle of RUN
        start_op(1, 18'd1000, 18'd7);
        repeat (4) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check_eq("mrst_busy", 64'(busy1), 64'd0);
        check_eq("mrst_done", 64'(done1), 64'd0);
        check_eq("mrst_q",    64'(q1),    64'd0);
        check_eq("mrst_rem",  64'(rem1),  64'd0);
        check_eq("mrst_qs",   64'(qs1),   64'd0);
        @(negedge clk);
        nrst = 1'b1;
        run_op(1, "post_rst", 18'd3, 18'd4, 28, 64'd192, 64'd0, 64'hC0, 1'b0);

        // FRAC_W=0, OUT_W=18 instance: N=18, latency 20
        run_op(2, "w100_7",    18'd100,    18'd7,   20, 64'd14,     64'd2,   64'd14,     1'b0);
        run_op(2, "wmax_1",    18'd262143, 18'd1,   20, 64'd262143, 64'd0,   64'd262143, 1'b0);
        run_op(2, "w5_9",      18'd5,      18'd9,   20, 64'd0,      64'd5,   64'd0,      1'b0);
        run_op(2, "w200k_333", 18'd200000, 18'd333, 20, 64'd600,    64'd200, 64'd600,    1'b0);
        for (int i = 0; i < 4; i++) begin
            rdvd = 18'($urandom_range(0, 262143));
            rdvs = 18'($urandom_range(1, 262143));
            run_op(2, $sformatf("rnd%0d", i), rdvd, rdvs, 20,
                   64'(rdvd / rdvs), 64'(rdvd % rdvs), 64'(rdvd / rdvs), 1'b0);
        end

        // Back-to-back: new start sampled on the FINISH edge of 100/7
        start_op(2, 18'd100, 18'd7);
        repeat (18) @(negedge clk);
        check_eq("b2b_fin_busy", 64'(busy2), 64'd1);
        check_eq("b2b_fin_done", 64'(done2), 64'd0);
        dividend = 18'd200000;
        divisor  = 18'd333;
        start2   = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check_eq("b2b_first_done", 64'(done2), 64'd1);
        check_eq("b2b_first_q",    64'(q2),    64'd14);
        check_eq("b2b_first_rem",  64'(rem2),  64'd2);
        check_eq("b2b_busy",       64'(busy2), 64'd1);
        wait_done(2, "b2b_second", lat);
        check_eq("b2b_second_lat", 64'(lat), 64'd20);
        check_eq("b2b_second_q",   64'(q2),   64'd600);
        check_eq("b2b_second_rem", 64'(rem2), 64'd200);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
